// File: rtl/interleaved_fifo_pkg.sv
// Shared helpers for the two-bank interleaved arbiter: address split,
// starvation-counter sizing and the per-bank grant encoding.
package interleaved_fifo_pkg;

   // Bit 0 of a requester address selects the bank; the remaining bits index the bank word.
   localparam int BANK_BIT = 0;

   typedef enum logic [1:0] {
      GRANT_NONE = 2'b00,
      GRANT_A    = 2'b01,
      GRANT_B    = 2'b10
   } grant_t;

   function automatic int bank_word_width(input int lb_depth);
      return (lb_depth > 1) ? lb_depth - 1 : 1;
   endfunction

   function automatic int starve_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/bank_grant.sv
// Two-way grant for one bank: A normally wins a conflict, B wins once it has
// been starved for long enough.
module bank_grant
   import interleaved_fifo_pkg::*;
(
   input  logic   a_req,
   input  logic   b_req,
   input  logic   b_starved,
   output grant_t grant
);

   // NOTE: assigning a default before any branch keeps this block free of inferred latches.
   always_comb begin
      grant = GRANT_NONE;
      if (a_req && b_req) begin
         grant = b_starved ? GRANT_B : GRANT_A;
      end else if (a_req) begin
         grant = GRANT_A;
      end else if (b_req) begin
         grant = GRANT_B;
      end
   end

endmodule

// File: rtl/interleaved_bank_arbiter.sv
// Arbitrates two requesters onto two address-interleaved memory banks, tracks
// read responses per requester and keeps conflict/starvation statistics.
module interleaved_bank_arbiter
   import interleaved_fifo_pkg::*;
#(
   parameter  int DATA_WIDTH    = 8,
   parameter  int FIFO_DEPTH    = 16,
   parameter  int STARVE_LIMIT  = 4,
   localparam int LB_FIFO_DEPTH = $clog2(FIFO_DEPTH)
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     clear,
   input  logic                     a_req_valid,
   output logic                     a_req_ready,
   input  logic                     a_req_we,
   input  logic [LB_FIFO_DEPTH-1:0] a_req_addr,
   input  logic [DATA_WIDTH-1:0]    a_req_wdata,
   output logic                     a_rsp_valid,
   output logic [DATA_WIDTH-1:0]    a_rsp_data,
   input  logic                     b_req_valid,
   output logic                     b_req_ready,
   input  logic                     b_req_we,
   input  logic [LB_FIFO_DEPTH-1:0] b_req_addr,
   input  logic [DATA_WIDTH-1:0]    b_req_wdata,
   output logic                     b_rsp_valid,
   output logic [DATA_WIDTH-1:0]    b_rsp_data,
   output logic [LB_FIFO_DEPTH-1:0] mem0_addr,
   output logic [DATA_WIDTH-1:0]    mem0_din,
   input  logic [DATA_WIDTH-1:0]    mem0_dout,
   output logic                     mem0_wr_enable,
   output logic                     mem0_rd_enable,
   output logic [LB_FIFO_DEPTH-1:0] mem1_addr,
   output logic [DATA_WIDTH-1:0]    mem1_din,
   input  logic [DATA_WIDTH-1:0]    mem1_dout,
   output logic                     mem1_wr_enable,
   output logic                     mem1_rd_enable,
   output logic [15:0]              conflict_cnt
);

   localparam int WORD_W   = bank_word_width(LB_FIFO_DEPTH);
   localparam int STARVE_W = starve_width(STARVE_LIMIT);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   typedef struct packed {
      logic                     wr_enable;
      logic                     rd_enable;
      logic [LB_FIFO_DEPTH-1:0] addr;
      logic [DATA_WIDTH-1:0]    din;
   } mem_port_t;

   logic                     a_active, b_active, a_bank, b_bank, conflict, b_starved;
   logic [LB_FIFO_DEPTH-1:0] a_word, b_word;
   logic                     a_rsp_bank, b_rsp_bank;
   logic [STARVE_W-1:0]      starve_cnt;
   grant_t                   grant0, grant1;
   mem_port_t                port0, port1;

   // Gating the requests with rstn holds every combinational output at its reset value.
   assign a_active  = rstn && a_req_valid;
   assign b_active  = rstn && b_req_valid;
   assign a_bank    = a_req_addr[BANK_BIT];
   assign b_bank    = b_req_addr[BANK_BIT];
   assign a_word    = LB_FIFO_DEPTH'(a_req_addr[BANK_BIT+1 +: WORD_W]);
   assign b_word    = LB_FIFO_DEPTH'(b_req_addr[BANK_BIT+1 +: WORD_W]);
   assign conflict  = a_active && b_active && (a_bank == b_bank);
   assign b_starved = (starve_cnt >= STARVE_MAX);

   bank_grant u_bank0_grant (
      .a_req     (a_active && !a_bank),
      .b_req     (b_active && !b_bank),
      .b_starved (b_starved),
      .grant     (grant0)
   );

   bank_grant u_bank1_grant (
      .a_req     (a_active && a_bank),
      .b_req     (b_active && b_bank),
      .b_starved (b_starved),
      .grant     (grant1)
   );

   assign a_req_ready = (grant0 == GRANT_A) || (grant1 == GRANT_A);
   assign b_req_ready = (grant0 == GRANT_B) || (grant1 == GRANT_B);

   function automatic mem_port_t access(input logic                     we,
                                        input logic [LB_FIFO_DEPTH-1:0] word,
                                        input logic [DATA_WIDTH-1:0]    wdata);
      mem_port_t port;
      port           = '0;
      port.wr_enable = we;
      port.rd_enable = !we;
      port.addr      = word;
      port.din       = we ? wdata : '0;
      return port;
   endfunction

   always_comb begin
      port0 = '0;
      port1 = '0;
      case (grant0)
         GRANT_A: port0 = access(a_req_we, a_word, a_req_wdata);
         GRANT_B: port0 = access(b_req_we, b_word, b_req_wdata);
         default: port0 = '0;
      endcase
      case (grant1)
         GRANT_A: port1 = access(a_req_we, a_word, a_req_wdata);
         GRANT_B: port1 = access(b_req_we, b_word, b_req_wdata);
         default: port1 = '0;
      endcase
   end

   assign mem0_wr_enable = port0.wr_enable;
   assign mem0_rd_enable = port0.rd_enable;
   assign mem0_addr      = port0.addr;
   assign mem0_din       = port0.din;
   assign mem1_wr_enable = port1.wr_enable;
   assign mem1_rd_enable = port1.rd_enable;
   assign mem1_addr      = port1.addr;
   assign mem1_din       = port1.din;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a_rsp_valid <= 1'b0;
         b_rsp_valid <= 1'b0;
         a_rsp_bank  <= 1'b0;
         b_rsp_bank  <= 1'b0;
      end else begin
         a_rsp_valid <= a_req_ready && !a_req_we;
         b_rsp_valid <= b_req_ready && !b_req_we;
         a_rsp_bank  <= a_bank;
         b_rsp_bank  <= b_bank;
      end
   end

   // The remembered bank steers each requester to the bank it read last cycle.
   assign a_rsp_data = !a_rsp_valid ? '0 : (a_rsp_bank ? mem1_dout : mem0_dout);
   assign b_rsp_data = !b_rsp_valid ? '0 : (b_rsp_bank ? mem1_dout : mem0_dout);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         conflict_cnt <= '0;
         starve_cnt   <= '0;
      end else if (clear) begin
         conflict_cnt <= '0;
         starve_cnt   <= '0;
      end else begin
         if (conflict && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
         end
         if (b_active && !b_req_ready) begin
            if (starve_cnt != '1) begin
               starve_cnt <= starve_cnt + 1'b1;
            end
         end else begin
            starve_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_interleaved_bank_arbiter.sv
// Directed bench for interleaved_bank_arbiter: read responses are predicted into
// per-requester queues and checked by an independent monitor.
module tb_interleaved_bank_arbiter;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       clear = 1'b0;
   logic       a_req_valid = 1'b0, a_req_we = 1'b0;
   logic [3:0] a_req_addr = '0;
   logic [7:0] a_req_wdata = '0;
   logic       b_req_valid = 1'b0, b_req_we = 1'b0;
   logic [3:0] b_req_addr = '0;
   logic [7:0] b_req_wdata = '0;
   logic       a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
   logic [7:0] a_rsp_data, b_rsp_data;
   logic [3:0] mem0_addr, mem1_addr;
   logic [7:0] mem0_din, mem1_din;
   logic [7:0] mem0_dout = '0, mem1_dout = '0;
   logic       mem0_wr_enable, mem0_rd_enable, mem1_wr_enable, mem1_rd_enable;
   logic [15:0] conflict_cnt;

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t       a_q[$];
   exp_t       b_q[$];
   logic [7:0] a_exp = '0, b_exp = '0;
   logic [7:0] bank0 [8];
   logic [7:0] bank1 [8];
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;

   interleaved_bank_arbiter #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rstn(rstn), .clear(clear),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
      .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
      .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
      .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
      .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
      .mem0_addr(mem0_addr), .mem0_din(mem0_din), .mem0_dout(mem0_dout),
      .mem0_wr_enable(mem0_wr_enable), .mem0_rd_enable(mem0_rd_enable),
      .mem1_addr(mem1_addr), .mem1_din(mem1_din), .mem1_dout(mem1_dout),
      .mem1_wr_enable(mem1_wr_enable), .mem1_rd_enable(mem1_rd_enable),
      .conflict_cnt(conflict_cnt)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read bank memories sitting behind the arbiter.
   always @(posedge clk) begin
      if (mem0_wr_enable) bank0[mem0_addr[2:0]] <= mem0_din;
      if (mem0_rd_enable) mem0_dout <= bank0[mem0_addr[2:0]];
      if (mem1_wr_enable) bank1[mem1_addr[2:0]] <= mem1_din;
      if (mem1_rd_enable) mem1_dout <= bank1[mem1_addr[2:0]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every response must match the oldest prediction, in data and in cycle.
   always @(negedge clk) begin
      exp_t e;
      if (a_rsp_valid) begin
         if (a_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_rsp_unexpected actual=1 expected=0");
         end else begin
            e = a_q.pop_front();
            check("a_rsp_data", 32'(a_rsp_data), 32'(e.data));
            check("a_rsp_cycle", cyc, e.due);
         end
      end
      if (b_rsp_valid) begin
         if (b_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_rsp_unexpected actual=1 expected=0");
         end else begin
            e = b_q.pop_front();
            check("b_rsp_data", 32'(b_rsp_data), 32'(e.data));
            check("b_rsp_cycle", cyc, e.due);
         end
      end
   end

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic drive_a(input logic v, input logic we, input logic [3:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp);
      a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_exp = exp;
   endtask

   task automatic drive_b(input logic v, input logic we, input logic [3:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp);
      b_req_valid = v; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_exp = exp;
   endtask

   task automatic sample(input logic exp_a, input logic exp_b, input string tag);
      @(negedge clk);
      check({tag, "_a_ready"}, 32'(a_req_ready), 32'(exp_a));
      check({tag, "_b_ready"}, 32'(b_req_ready), 32'(exp_b));
      if (a_req_valid && !a_req_we && exp_a) a_q.push_back('{a_exp, cyc + 1});
      if (b_req_valid && !b_req_we && exp_b) b_q.push_back('{b_exp, cyc + 1});
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input logic exp_a, input logic exp_b, input string tag);
      sample(exp_a, exp_b, tag);
      advance();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_a_ready"}, 32'(a_req_ready), 0);
      check({tag, "_b_ready"}, 32'(b_req_ready), 0);
      check({tag, "_a_rsp_valid"}, 32'(a_rsp_valid), 0);
      check({tag, "_b_rsp_valid"}, 32'(b_rsp_valid), 0);
      check({tag, "_a_rsp_data"}, 32'(a_rsp_data), 0);
      check({tag, "_mem_enables"},
            32'({mem0_wr_enable, mem0_rd_enable, mem1_wr_enable, mem1_rd_enable}), 0);
      check({tag, "_mem_addr"}, 32'({mem0_addr, mem1_addr}), 0);
      check({tag, "_mem_din"}, 32'({mem0_din, mem1_din}), 0);
      check({tag, "_conflict_cnt"}, 32'(conflict_cnt), 0);
   endtask

   initial begin
      bit exp_a_seq [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         bank0[i] = '0;
         bank1[i] = '0;
      end

      // Requests held during reset must not leak onto any output.
      drive_a(1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
      drive_b(1'b1, 1'b1, 4'd1, 8'h55, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      drive_a(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      drive_b(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      advance();
      rstn = 1'b1;
      advance();

      // Writes to different banks proceed together.
      drive_a(1'b1, 1'b1, 4'd2, 8'h11, 8'h00);
      drive_b(1'b1, 1'b1, 4'd3, 8'h22, 8'h00);
      sample(1'b1, 1'b1, "split_wr");
      check("split_wr_mem0_wr", 32'(mem0_wr_enable), 1);
      check("split_wr_mem1_wr", 32'(mem1_wr_enable), 1);
      check("split_wr_rd", 32'({mem0_rd_enable, mem1_rd_enable}), 0);
      check("split_wr_mem0_addr", 32'(mem0_addr), 1);
      check("split_wr_mem1_addr", 32'(mem1_addr), 1);
      check("split_wr_mem0_din", 32'(mem0_din), 32'h11);
      check("split_wr_mem1_din", 32'(mem1_din), 32'h22);
      advance();
      drive_b(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);

      // Four writes then four back-to-back reads alternating banks.
      for (int i = 0; i < 4; i++) begin
         drive_a(1'b1, 1'b1, 4'(i), 8'(8'hA0 + i), 8'h00);
         cycle(1'b1, 1'b0, "seq_wr");
      end
      for (int i = 0; i < 4; i++) begin
         drive_a(1'b1, 1'b0, 4'(i), 8'h00, 8'(8'hA0 + i));
         cycle(1'b1, 1'b0, "seq_rd");
      end
      drive_a(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      cycle(1'b0, 1'b0, "seq_idle");
      cycle(1'b0, 1'b0, "seq_idle");
      check("seq_a_q_empty", a_q.size(), 0);

      // Same-bank read conflict: B wins only after four denied cycles.
      drive_a(1'b1, 1'b1, 4'd4, 8'h44, 8'h00);
      cycle(1'b1, 1'b0, "conf_wr");
      drive_a(1'b1, 1'b0, 4'd4, 8'h00, 8'h44);
      drive_b(1'b1, 1'b0, 4'd4, 8'h00, 8'h44);
      for (int i = 0; i < 6; i++) begin
         cycle(exp_a_seq[i], !exp_a_seq[i], "conf_rd");
      end
      drive_a(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      drive_b(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      cycle(1'b0, 1'b0, "conf_idle");
      cycle(1'b0, 1'b0, "conf_idle");
      check("conf_cnt", 32'(conflict_cnt), 6);
      check("conf_queues_empty", a_q.size() + b_q.size(), 0);

      // Clear, then saturate the conflict counter with same-bank writes.
      clear = 1'b1;
      advance();
      clear = 1'b0;
      @(negedge clk);
      check("clear_cnt", 32'(conflict_cnt), 0);
      advance();
      drive_a(1'b1, 1'b1, 4'd4, 8'h5A, 8'h00);
      drive_b(1'b1, 1'b1, 4'd6, 8'hA5, 8'h00);
      repeat (65534) @(posedge clk);
      @(negedge clk);
      check("sat_near_max", 32'(conflict_cnt), 32'hFFFE);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("sat_hold", 32'(conflict_cnt), 32'hFFFF);
      advance();
      clear = 1'b1;
      advance();
      clear = 1'b0;
      @(negedge clk);
      check("sat_clear_priority", 32'(conflict_cnt), 0);
      drive_a(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      drive_b(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      advance();

      // Reset in the cycle after a granted read drops the response.
      drive_a(1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
      drive_b(1'b1, 1'b1, 4'd2, 8'h77, 8'h00);
      @(negedge clk);
      check("rst_rd_a_ready", 32'(a_req_ready), 1);
      check("rst_rd_b_ready", 32'(b_req_ready), 0);
      advance();
      rstn = 1'b0;
      drive_a(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      drive_b(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      @(negedge clk);
      check_reset_outputs("mid_rst");
      advance();
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_a_rsp_valid", 32'(a_rsp_valid), 0);
         advance();
      end
      check("final_queues_empty", a_q.size() + b_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
